clk_rst_conditioner: RTL

Sits directly downstream of the board PLL on the 25 MHz domain. It consumes the PLL lock flag and the raw board reset button, and produces the single clean system reset for the Apple-1 core, video and UART.
- Reset is released only after lock has been stable for a programmable time, then stretched to a minimum width.
- Loss of lock, or a debounced button press, re-asserts reset.

---
 rtl/clk_rst_pkg.sv | 26 ++
 rtl/clk_rst_conditioner_sync_ff.sv | 33 +++
 rtl/clk_rst_conditioner.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/clk_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_pkg
// Description : Shared constants for the 25 MHz clock/reset conditioner:
//               FSM state encodings, lock-loss counter width and a helper
//               that sizes terminal-count counters.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_rst_pkg;

    // FSM state encodings (fixed so downstream debug tooling can decode them)
    localparam logic [1:0] S_LOCK_WAIT = 2'd0;
    localparam logic [1:0] S_STRETCH   = 2'd1;
    localparam logic [1:0] S_BTN_HOLD  = 2'd2;
    localparam logic [1:0] S_RUN       = 2'd3;

    // Width of the saturating lock-loss event counter
    localparam int LOCK_LOST_W = 8;

    // Counter width for a counter running 0 .. limit-1, never below 1 bit
    function automatic int cnt_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage : clk_rst_pkg
`default_nettype wire

// File: rtl/clk_rst_conditioner_sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Multi-flop synchronizer for a single asynchronous bit, with
//               a parameterised depth and a parameterised reset value so the
//               chain powers up in the "safe" level of the signal it carries.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the chain; oldest sample is the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/clk_rst_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_conditioner
// Description : Produces the single clean active-low system reset for the
//               25 MHz domain. Reset is released only after the PLL lock flag
//               has been stable for LOCK_CYCLES, then held a further
//               STRETCH_CYCLES. Lock loss or a debounced button press
//               re-asserts it. Lock-loss events are counted (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module clk_rst_conditioner
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_CYCLES     = 1024,
    parameter int STRETCH_CYCLES  = 16,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                   clk25,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   button_n,
    output logic                   sys_rst_n,
    output logic [LOCK_LOST_W-1:0] lock_lost_cnt
);

    localparam int c_lock_w    = cnt_width(LOCK_CYCLES);
    localparam int c_stretch_w = cnt_width(STRETCH_CYCLES);
    localparam int c_deb_w     = cnt_width(DEBOUNCE_CYCLES);

    localparam logic [c_lock_w-1:0]    c_lock_last    = c_lock_w'(LOCK_CYCLES - 1);
    localparam logic [c_stretch_w-1:0] c_stretch_last = c_stretch_w'(STRETCH_CYCLES - 1);
    localparam logic [c_deb_w-1:0]     c_deb_last     = c_deb_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [LOCK_LOST_W-1:0] c_lost_max     = '1;

    logic                   w_locked_s;
    logic                   w_btn_s;

    logic                   r_button_db;
    logic [c_deb_w-1:0]     r_deb_cnt;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_lock_w-1:0]    r_lock_cnt;
    logic [c_lock_w-1:0]    w_lock_cnt_nxt;
    logic [c_stretch_w-1:0] r_stretch_cnt;
    logic [c_stretch_w-1:0] w_stretch_cnt_nxt;
    logic [LOCK_LOST_W-1:0] r_lock_lost_cnt;
    logic [LOCK_LOST_W-1:0] w_lock_lost_nxt;
    logic                   r_sys_rst_n;

    // Lock flag powers up "unlocked" so nothing is released before a real lock
    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_locked (
        .clk   (clk25),
        .rst_n (rst_n),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    // Button is active-low, so its chain powers up "released"
    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_button (
        .clk   (clk25),
        .rst_n (rst_n),
        .i_d   (button_n),
        .o_q   (w_btn_s)
    );

    // Debouncer: accept a new button level only after it differs for DEBOUNCE_CYCLES
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_button_db <= 1'b1;
            r_deb_cnt   <= '0;
        end else if (w_btn_s == r_button_db) begin
            r_deb_cnt   <= '0;
        end else if (r_deb_cnt == c_deb_last) begin
            r_button_db <= w_btn_s;
            r_deb_cnt   <= '0;
        end else begin
            r_deb_cnt   <= r_deb_cnt + 1'b1;
        end
    end

    // Next-state and counter logic; lock loss outranks the button, which
    // outranks the per-state progress rules
    always_comb begin
        w_state_nxt       = r_state;
        w_lock_cnt_nxt    = r_lock_cnt;
        w_stretch_cnt_nxt = r_stretch_cnt;
        w_lock_lost_nxt   = r_lock_lost_cnt;

        if (!w_locked_s && (r_state != S_LOCK_WAIT)) begin
            w_state_nxt       = S_LOCK_WAIT;
            w_lock_cnt_nxt    = '0;
            w_stretch_cnt_nxt = '0;
            if (r_lock_lost_cnt != c_lost_max) begin
                w_lock_lost_nxt = r_lock_lost_cnt + 1'b1;
            end
        end else if (!r_button_db && ((r_state == S_STRETCH) || (r_state == S_RUN))) begin
            w_state_nxt       = S_BTN_HOLD;
            w_stretch_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_LOCK_WAIT: begin
                    // A held button is deliberately ignored here; it is
                    // caught one cycle after entering S_STRETCH
                    if (!w_locked_s) begin
                        w_lock_cnt_nxt = '0;
                    end else if (r_lock_cnt == c_lock_last) begin
                        w_state_nxt       = S_STRETCH;
                        w_lock_cnt_nxt    = '0;
                        w_stretch_cnt_nxt = '0;
                    end else begin
                        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                    end
                end
                S_STRETCH: begin
                    if (r_stretch_cnt == c_stretch_last) begin
                        w_state_nxt       = S_RUN;
                        w_stretch_cnt_nxt = '0;
                    end else begin
                        w_stretch_cnt_nxt = r_stretch_cnt + 1'b1;
                    end
                end
                S_BTN_HOLD: begin
                    if (r_button_db) begin
                        w_state_nxt       = S_STRETCH;
                        w_stretch_cnt_nxt = '0;
                    end
                end
                S_RUN: begin
                    w_state_nxt = S_RUN;
                end
                default: begin
                    w_state_nxt = S_LOCK_WAIT;
                end
            endcase
        end
    end

    // State, counters and lock-loss statistic registers
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_LOCK_WAIT;
            r_lock_cnt      <= '0;
            r_stretch_cnt   <= '0;
            r_lock_lost_cnt <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_lock_cnt      <= w_lock_cnt_nxt;
            r_stretch_cnt   <= w_stretch_cnt_nxt;
            r_lock_lost_cnt <= w_lock_lost_nxt;
        end
    end

    // Registered reset output so it never glitches on state-decode hazards
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_sys_rst_n <= 1'b0;
        end else begin
            r_sys_rst_n <= (w_state_nxt == S_RUN);
        end
    end

    assign sys_rst_n     = r_sys_rst_n;
    assign lock_lost_cnt = r_lock_lost_cnt;

endmodule : clk_rst_conditioner
`default_nettype wire
